pipelined_shifter: RTL and testbench
====================================

# pipelined_shifter

Parametrised, pipelined barrel shifter for the ALU datapath. Successor to the single-cycle combinational shifter. Supports logical/arithmetic shifts and rotate, with one register per shift stage and a valid/ready handshake on both sides. Accepts one operation per cycle and produces a carry-out (last bit shifted out) and a zero flag alongside the result.

## Interface
- BUS_WIDTH, 8, data width W; must be a power of two, at least 2
- BUS_WIDTH_BITS, 3, log2(BUS_WIDTH); also the number of pipeline stages N

- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous, active-low reset
- in_valid  in  1  request present on in_* this cycle
- in_ready  out  1  block accepts the request this cycle
- in_a  in  W  operand
- in_amt  in  BUS_WIDTH_BITS  shift amount, 0..W-1
- in_op  in  2  operation: 00 SLL, 01 SRL, 10 SRA, 11 ROR
- out_valid  out  1  result present on out_*
- out_ready  in  1  consumer accepts the result
- out_y  out  W  result
- out_carry  out  1  last bit shifted or rotated out; 0 when amount is 0
- out_zero  out  1  out_y == 0

## Operation
- Stage k (k = 0..N-1) shifts by 2^k when amt[k] = 1, otherwise passes the data through. Each stage carries op, remaining amt bits, data, carry and a valid bit in its register.
- SLL: zero fill from the LSB. SRL: zero fill from the MSB. SRA: fill with the sign bit of in_a (bit W-1), which stays fixed through every stage. ROR: bits leaving the LSB re-enter at the MSB.
- Carry, for a stage that shifts by s: SLL takes stage-input bit W-s; SRL/SRA/ROR take stage-input bit s-1. A stage that does not shift passes the carry through. Carry into stage 0 is 0.
- Net carry equals the original bit W-n for SLL and the original bit n-1 otherwise, where n = in_amt.
- out_zero is derived from the final-stage data register. out_y, out_carry and out_zero are all register outputs.
- Global stall rule: en = ~out_valid | out_ready.
  - in_ready = en.
  - When en = 1, every stage register loads from its predecessor. Stage 0 loads in_* with valid = in_valid & in_ready.
  - When en = 0, all stages hold.
  - Bubbles are not compacted.
- No transaction is dropped or duplicated. Output data is stable while out_valid = 1 and out_ready = 0.

## Timing
- Latency: exactly N cycles from the accept edge (in_valid & in_ready) to out_valid = 1, assuming no stall. Each stall cycle adds one cycle.
- Throughput: one operation per cycle while out_ready = 1.
- Reset (rst_n low, asynchronous): all valid bits 0, all data/carry/op registers 0. Outputs read out_valid = 0, out_y = 0, out_carry = 0, out_zero = 1, in_ready = 1.
- Reset asserted mid-operation discards all in-flight operations. The first accept after reset release yields a result N cycles later.
- Simultaneous accept on input and output in the same cycle is legal and required for full throughput.
- in_amt = 0: out_y = in_a, out_carry = 0 for every op.
- in_ready depends combinationally on out_ready. No other combinational path runs from input to output.

## Structure
- Package shift_pkg holds:
  - op encoding constants SHIFT_SLL, SHIFT_SRL, SHIFT_SRA, SHIFT_ROR
  - a 2-bit shift_op_t typedef
- Sub-module shift_stage:
  - parameters BUS_WIDTH and STAGE
  - combinational shift by 2^STAGE under enable, plus carry selection
  - instantiated N times by a generate loop in pipelined_shifter, which owns all registers and the handshake

## Test plan
- W=8, out_ready=1, SLL a=0x81 amt=1 -> after 3 cycles out_y=0x02, carry=1, zero=0.
- SRA a=0x90 amt=3 -> out_y=0xF2, carry=0. SRL same operands -> out_y=0x12, carry=0.
- ROR a=0x01 amt=1 -> out_y=0x80, carry=1. SLL a=0x80 amt=1 -> out_y=0x00, carry=1, zero=1.
- Back-to-back accepts of 8 random ops each cycle -> 8 consecutive out_valid cycles, results matching the reference model in order.
- Hold out_ready=0 with the pipe full for 5 cycles -> in_ready=0, out_* stable. Release -> the in-order stream resumes with none lost.
- Assert rst_n low with 2 ops in flight -> out_valid=0 and out_zero=1 immediately (asynchronously), in_ready=1. No stale result appears after release.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared definitions for the pipelined barrel shifter: operation encoding
// used by both the pipeline top and the per-stage shift logic.
package shift_pkg;

  typedef logic [1:0] shift_op_t;

  localparam shift_op_t SHIFT_SLL = 2'b00;
  localparam shift_op_t SHIFT_SRL = 2'b01;
  localparam shift_op_t SHIFT_SRA = 2'b10;
  localparam shift_op_t SHIFT_ROR = 2'b11;

endpackage

// File: rtl/shift_stage.sv
// One combinational barrel-shifter stage: shifts by 2^STAGE when enabled and
// selects the bit that leaves the word as the new carry.
module shift_stage
  import shift_pkg::*;
#(
  parameter int BUS_WIDTH = 8,
  parameter int STAGE     = 0
) (
  input  logic [BUS_WIDTH-1:0] data_in,
  input  logic                 carry_in,
  input  shift_op_t            op,
  input  logic                 shift_en,
  output logic [BUS_WIDTH-1:0] data_out,
  output logic                 carry_out
);

  localparam int SHIFT = 1 << STAGE;

  // SRA relies on the MSB still holding the original sign bit, which every
  // earlier SRA stage preserves by filling with it.
  always_comb begin
    data_out  = data_in;
    carry_out = carry_in;
    if (shift_en) begin
      unique case (op)
        SHIFT_SLL: begin
          data_out  = data_in << SHIFT;
          carry_out = data_in[BUS_WIDTH-SHIFT];
        end
        SHIFT_SRL: begin
          data_out  = data_in >> SHIFT;
          carry_out = data_in[SHIFT-1];
        end
        SHIFT_SRA: begin
          data_out  = $signed(data_in) >>> SHIFT;
          carry_out = data_in[SHIFT-1];
        end
        SHIFT_ROR: begin
          data_out  = (data_in >> SHIFT) | (data_in << (BUS_WIDTH - SHIFT));
          carry_out = data_in[SHIFT-1];
        end
      endcase
    end
  end

endmodule

// File: rtl/pipelined_shifter.sv
// Pipelined barrel shifter: one register per shift stage, a single global
// stall enable, and valid/ready handshakes on both sides.
module pipelined_shifter
  import shift_pkg::*;
#(
  parameter int BUS_WIDTH      = 8,
  parameter int BUS_WIDTH_BITS = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [BUS_WIDTH-1:0]      in_a,
  input  logic [BUS_WIDTH_BITS-1:0] in_amt,
  input  shift_op_t                 in_op,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [BUS_WIDTH-1:0]      out_y,
  output logic                      out_carry,
  output logic                      out_zero
);

  localparam int N = BUS_WIDTH_BITS;

  logic                      en;
  logic [N-1:0]              valid_q;
  logic [N-1:0]              carry_q;
  logic [N-1:0]              carry_d;
  logic [BUS_WIDTH-1:0]      data_q [N];
  logic [BUS_WIDTH-1:0]      data_d [N];
  shift_op_t                 op_q   [N];
  logic [BUS_WIDTH_BITS-1:0] amt_q  [N];

  // Whole pipe advances together; a stalled output freezes every stage.
  assign en       = ~out_valid | out_ready;
  assign in_ready = en;

  genvar k;
  generate
    for (k = 0; k < N; k++) begin : g_stage
      if (k == 0) begin : g_first
        shift_stage #(.BUS_WIDTH(BUS_WIDTH), .STAGE(0)) u_stage (
          .data_in  (in_a),
          .carry_in (1'b0),
          .op       (in_op),
          .shift_en (in_amt[0]),
          .data_out (data_d[0]),
          .carry_out(carry_d[0])
        );
      end else begin : g_rest
        shift_stage #(.BUS_WIDTH(BUS_WIDTH), .STAGE(k)) u_stage (
          .data_in  (data_q[k-1]),
          .carry_in (carry_q[k-1]),
          .op       (op_q[k-1]),
          .shift_en (amt_q[k-1][k]),
          .data_out (data_d[k]),
          .carry_out(carry_d[k])
        );
      end
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      carry_q <= '0;
      for (int i = 0; i < N; i++) begin
        data_q[i] <= '0;
        op_q[i]   <= SHIFT_SLL;
        amt_q[i]  <= '0;
      end
    end else if (en) begin
      valid_q[0] <= in_valid & en;
      op_q[0]    <= in_op;
      amt_q[0]   <= in_amt;
      for (int i = 1; i < N; i++) begin
        valid_q[i] <= valid_q[i-1];
        op_q[i]    <= op_q[i-1];
        amt_q[i]   <= amt_q[i-1];
      end
      for (int i = 0; i < N; i++) begin
        data_q[i] <= data_d[i];
      end
      carry_q <= carry_d;
    end
  end

  assign out_valid = valid_q[N-1];
  assign out_y     = data_q[N-1];
  assign out_carry = carry_q[N-1];
  assign out_zero  = (data_q[N-1] == '0);

endmodule

// File: tb/tb_pipelined_shifter.sv
// Scoreboard bench for pipelined_shifter: stimulus pushes expected results,
// a negedge monitor pops and compares whenever a result is transferred.
module tb_pipelined_shifter;

  localparam int W  = 8;
  localparam int NB = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [W-1:0]  in_a = '0;
  logic [NB-1:0] in_amt = '0;
  logic [1:0]    in_op = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [W-1:0]  out_y;
  logic          out_carry;
  logic          out_zero;

  typedef struct {
    logic [W-1:0] y;
    logic         c;
    logic         z;
    int           acc;
    bit           lat;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  int           checks = 0;
  int           errors = 0;
  int           cyc = 0;
  bit           lat_mode = 1'b0;
  int           run_len = 0;
  int           max_run = 0;
  bit           held = 1'b0;
  logic [W-1:0] held_y;
  logic         held_c;
  logic         held_z;

  pipelined_shifter #(.BUS_WIDTH(W), .BUS_WIDTH_BITS(NB)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_a     (in_a),
    .in_amt   (in_amt),
    .in_op    (in_op),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_y    (out_y),
    .out_carry(out_carry),
    .out_zero (out_zero)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference behaviour from plain integer arithmetic on the original operand.
  function automatic exp_t model(input logic [W-1:0] a, input logic [NB-1:0] amt,
                                 input logic [1:0] op);
    exp_t r;
    int   ua, sa, n, y, c;
    ua = int'(a);
    sa = a[W-1] ? ua - (1 << W) : ua;
    n  = int'(amt);
    c  = 0;
    case (op)
      2'b00: begin
        y = ua << n;
        if (n != 0) c = (ua >> (W - n)) & 1;
      end
      2'b01:   y = ua >> n;
      2'b10:   y = sa >>> n;
      default: y = (ua >> n) | (ua << (W - n));
    endcase
    if (op != 2'b00 && n != 0) c = (ua >> (n - 1)) & 1;
    r.y   = W'(y & ((1 << W) - 1));
    r.c   = c[0];
    r.z   = (r.y == '0);
    r.acc = 0;
    r.lat = 1'b0;
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Presents one op at posedge+1, waits for acceptance and records the expectation.
  task automatic applyStimulus(input logic [W-1:0] a, input logic [NB-1:0] amt,
                               input logic [1:0] op, input bit has_exp,
                               input logic [W-1:0] ey, input logic ec);
    exp_t e;
    int   waited;
    bit   done;
    waited   = 0;
    done     = 1'b0;
    in_a     = a;
    in_amt   = amt;
    in_op    = op;
    in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        if (has_exp) begin
          e.y = ey;
          e.c = ec;
        end else begin
          e = model(a, amt, op);
        end
        e.z   = (e.y == '0);
        e.acc = cyc;
        e.lat = lat_mode;
        sb.push_back(e);
        done = 1'b1;
      end else begin
        waited++;
        if (waited > 200) begin
          checks++;
          errors++;
          $display("[TB] FAIL accept_timeout: in_ready stayed 0, expected 1");
          done = 1'b1;
        end else begin
          @(posedge clk);
          #1;
          out_ready = 1'($urandom_range(1));
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk);
      n++;
    end
    checkOutput("drain_queue_empty", 32'(sb.size()), 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
  endtask

  // Monitor: transfers, hold stability under stall, and consecutive-valid runs.
  always @(negedge clk) begin
    if (!rst_n) begin
      held    = 1'b0;
      run_len = 0;
    end else begin
      if (held) begin
        checkOutput("hold_valid", 32'(out_valid), 32'd1);
        checkOutput("hold_y", 32'(out_y), 32'(held_y));
        checkOutput("hold_carry", 32'(out_carry), 32'(held_c));
        checkOutput("hold_zero", 32'(out_zero), 32'(held_z));
      end
      if (out_valid) begin
        run_len++;
        if (run_len > max_run) max_run = run_len;
      end else begin
        run_len = 0;
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_output: got y=0x%0h with no pending op, expected none", out_y);
        end else begin
          mon_e = sb.pop_front();
          checkOutput("out_y", 32'(out_y), 32'(mon_e.y));
          checkOutput("out_carry", 32'(out_carry), 32'(mon_e.c));
          checkOutput("out_zero", 32'(out_zero), 32'(mon_e.z));
          if (mon_e.lat) checkOutput("latency", 32'(cyc - mon_e.acc), 32'(NB));
        end
      end
      held   = out_valid && !out_ready;
      held_y = out_y;
      held_c = out_carry;
      held_z = out_zero;
    end
  end

  initial begin
    rst_n = 1'b0;
    #3;
    checkOutput("reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("reset_out_y", 32'(out_y), 32'd0);
    checkOutput("reset_out_carry", 32'(out_carry), 32'd0);
    checkOutput("reset_out_zero", 32'(out_zero), 32'd1);
    checkOutput("reset_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed operations");
    lat_mode = 1'b1;
    applyStimulus(8'h81, 3'd1, 2'b00, 1'b1, 8'h02, 1'b1);
    applyStimulus(8'h90, 3'd3, 2'b10, 1'b1, 8'hF2, 1'b0);
    applyStimulus(8'h90, 3'd3, 2'b01, 1'b1, 8'h12, 1'b0);
    applyStimulus(8'h01, 3'd1, 2'b11, 1'b1, 8'h80, 1'b1);
    applyStimulus(8'h80, 3'd1, 2'b00, 1'b1, 8'h00, 1'b1);
    applyStimulus(8'hA5, 3'd0, 2'b11, 1'b1, 8'hA5, 1'b0);
    applyStimulus(8'hC3, 3'd0, 2'b10, 1'b1, 8'hC3, 1'b0);
    applyStimulus(8'h03, 3'd7, 2'b00, 1'b1, 8'h80, 1'b1);
    applyStimulus(8'h80, 3'd7, 2'b10, 1'b1, 8'hFF, 1'b0);
    applyStimulus(8'h81, 3'd7, 2'b11, 1'b1, 8'h03, 1'b0);
    drain();

    $display("[TB] back-to-back random operations");
    max_run = 0;
    for (int i = 0; i < 8; i++)
      applyStimulus(W'($urandom), NB'($urandom), 2'($urandom), 1'b0, '0, 1'b0);
    drain();
    checkOutput("b2b_consecutive_valid", 32'(max_run), 32'd8);
    lat_mode = 1'b0;

    $display("[TB] output stall with full pipe");
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++)
      applyStimulus(W'($urandom), NB'($urandom), 2'($urandom), 1'b0, '0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checkOutput("stall_in_ready", 32'(in_ready), 32'd0);
      checkOutput("stall_out_valid", 32'(out_valid), 32'd1);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++)
      applyStimulus(W'($urandom), NB'($urandom), 2'($urandom), 1'b0, '0, 1'b0);
    drain();

    $display("[TB] random traffic with random backpressure");
    for (int i = 0; i < 150; i++) begin
      out_ready = ($urandom_range(3) != 0);
      if ($urandom_range(3) != 0)
        applyStimulus(W'($urandom), NB'($urandom), 2'($urandom), 1'b0, '0, 1'b0);
      else begin
        @(posedge clk);
        #1;
      end
    end
    drain();

    $display("[TB] reset with operations in flight");
    lat_mode = 1'b1;
    applyStimulus(8'h5A, 3'd2, 2'b00, 1'b0, '0, 1'b0);
    applyStimulus(8'hF0, 3'd4, 2'b10, 1'b0, '0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("async_reset_out_valid", 32'(out_valid), 32'd0);
    checkOutput("async_reset_out_zero", 32'(out_zero), 32'd1);
    checkOutput("async_reset_out_y", 32'(out_y), 32'd0);
    checkOutput("async_reset_in_ready", 32'(in_ready), 32'd1);
    sb.delete();
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checkOutput("no_stale_after_reset", 32'(out_valid), 32'd0);
    end
    @(posedge clk);
    #1;
    applyStimulus(8'h81, 3'd1, 2'b00, 1'b1, 8'h02, 1'b1);
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
